// File: rtl/voq_sched_pkg.sv
// Shared types and width helpers for the per-output-port VOQ transmit scheduler.
package voq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_e;

    // Index width that stays legal for a single-port build.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return clog2_min1(depth);
    endfunction

endpackage

// File: rtl/voq_tx_scheduler_rr_arbiter.sv
// Combinational masked round-robin pick: first requester strictly after rr_last,
// wrapping to the lowest requester when nothing above rr_last is asking.
module rr_arbiter
    import voq_sched_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int IDX_W     = clog2_min1(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     rr_last_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 any_o
);

    logic [NUM_PORTS-1:0] above_last;
    logic [NUM_PORTS-1:0] masked_req;
    logic [NUM_PORTS-1:0] pick_vec;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_mask
            localparam logic [IDX_W-1:0] GI_IDX = IDX_W'(gi);
            assign above_last[gi] = (GI_IDX > rr_last_i);
        end
    endgenerate

    assign masked_req = req_i & above_last;
    assign pick_vec   = (|masked_req) ? masked_req : req_i;
    assign any_o      = |req_i;

    // Descending scan so the lowest set bit of pick_vec is the final assignment.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (pick_vec[i]) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
                idx_o      = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voq_tx_scheduler.sv
// Per-output-port scheduler: round-robin among eligible VOQs, hands one frame
// pointer at a time to tx_mac_control and waits for the MAC to finish it.
module voq_tx_scheduler
    import voq_sched_pkg::*;
#(
    parameter  int NUM_PORTS    = 4,
    parameter  int VOQ_DEPTH    = 256,
    parameter  int BUSY_TIMEOUT = 64,
    localparam int PTR_W        = ptr_width(VOQ_DEPTH)
) (
    input  logic                       switch_clk,
    input  logic                       switch_rst,
    input  logic [NUM_PORTS-1:0]       req_valid_i,
    input  logic [NUM_PORTS*PTR_W-1:0] req_ptr_i,
    output logic [NUM_PORTS-1:0]       req_pop_o,
    input  logic [NUM_PORTS-1:0]       port_en_i,
    output logic                       tx_valid_o,
    output logic [PTR_W-1:0]           tx_ptr_o,
    input  logic                       tx_ready_i,
    output logic [NUM_PORTS-1:0]       grant_o,
    output logic [31:0]                frame_cnt_o,
    output logic                       err_timeout_o
);

    localparam int IDX_W = clog2_min1(NUM_PORTS);
    localparam int CNT_W = clog2_min1(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] RR_INIT  = IDX_W'(NUM_PORTS - 1);

    sched_state_e         state_q,     state_d;
    logic [PTR_W-1:0]     ptr_q,       ptr_d;
    logic [NUM_PORTS-1:0] grant_q,     grant_d;
    logic [IDX_W-1:0]     rr_last_q,   rr_last_d;
    logic [CNT_W-1:0]     busy_cnt_q,  busy_cnt_d;
    logic [31:0]          frame_cnt_q, frame_cnt_d;
    logic                 err_q,       err_d;

    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic [PTR_W-1:0]     ptr_arr [NUM_PORTS];

    assign eligible = req_valid_i & port_en_i;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ptr
            assign ptr_arr[gi] = req_ptr_i[gi*PTR_W +: PTR_W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .req_i     (eligible),
        .rr_last_i (rr_last_q),
        .grant_o   (arb_grant),
        .idx_o     (arb_idx),
        .any_o     (arb_any)
    );

    always_ff @(posedge switch_clk) begin
        if (switch_rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            rr_last_q   <= RR_INIT;
            busy_cnt_q  <= '0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            rr_last_q   <= rr_last_d;
            busy_cnt_q  <= busy_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    // Everything about the frame is captured in the decision cycle, so later
    // request/pointer/enable changes cannot disturb the in-flight frame.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        rr_last_d   = rr_last_q;
        busy_cnt_d  = busy_cnt_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (tx_ready_i && arb_any) begin
                    ptr_d     = ptr_arr[arb_idx];
                    grant_d   = arb_grant;
                    rr_last_d = arb_idx;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                busy_cnt_d = '0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tx_ready_i) begin
                    busy_cnt_d = '0;
                    state_d    = WAIT_DONE;
                end else if (busy_cnt_q == CNT_LAST) begin
                    // MAC never acknowledged the frame: give up without counting it.
                    busy_cnt_d = '0;
                    err_d      = 1'b1;
                    grant_d    = '0;
                    state_d    = IDLE;
                end else begin
                    busy_cnt_d = busy_cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (tx_ready_i) begin
                    frame_cnt_d = frame_cnt_q + 32'd1;
                    grant_d     = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx_valid_o    = (state_q == ISSUE) && tx_ready_i;
    assign req_pop_o     = (state_q == ISSUE) ? grant_q : '0;
    assign tx_ptr_o      = ptr_q;
    assign grant_o       = grant_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_voq_tx_scheduler.sv
// Bench for voq_tx_scheduler: directed vector table, hand sequences for the
// multi-cycle cases, then randomized traffic against a transaction-level model.
module tb_voq_tx_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_ptr;
    logic [3:0]  req_pop;
    logic [3:0]  port_en;
    logic        tx_valid;
    logic [7:0]  tx_ptr;
    logic        tx_ready;
    logic [3:0]  grant;
    logic [31:0] frame_cnt;
    logic        err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    voq_tx_scheduler #(
        .NUM_PORTS    (4),
        .VOQ_DEPTH    (256),
        .BUSY_TIMEOUT (64)
    ) dut (
        .switch_clk    (clk),
        .switch_rst    (rst),
        .req_valid_i   (req_valid),
        .req_ptr_i     (req_ptr),
        .req_pop_o     (req_pop),
        .port_en_i     (port_en),
        .tx_valid_o    (tx_valid),
        .tx_ptr_o      (tx_ptr),
        .tx_ready_i    (tx_ready),
        .grant_o       (grant),
        .frame_cnt_o   (frame_cnt),
        .err_timeout_o (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner of the in-flight frame (-1 = none) and the phase of its life.
    int          m_owner;
    bit          m_issue;
    bit          m_wait_drop;
    int          m_wait;
    int          m_rr;
    logic [7:0]  m_ptr;
    logic [31:0] m_frames;
    bit          m_err;

    function automatic void model_step();
        logic [3:0] elig;
        elig = req_valid & port_en;
        if (rst) begin
            m_owner = -1; m_issue = 0; m_wait_drop = 0; m_wait = 0;
            m_rr = 3; m_ptr = 8'h00; m_frames = 32'd0; m_err = 0;
            return;
        end
        if (m_owner < 0) begin
            if (tx_ready && elig != 4'b0000) begin
                for (int s = 1; s <= 4; s++) begin
                    int p;
                    p = (m_rr + s) % 4;
                    if (elig[p]) begin
                        m_owner = p; m_rr = p; m_ptr = req_ptr[p*8 +: 8]; m_issue = 1;
                        break;
                    end
                end
            end
        end else if (m_issue) begin
            m_issue = 0; m_wait_drop = 1; m_wait = 0;
        end else if (m_wait_drop) begin
            if (!tx_ready) begin
                m_wait_drop = 0;
            end else begin
                m_wait++;
                if (m_wait == 64) begin
                    m_err = 1; m_owner = -1; m_wait_drop = 0;
                end
            end
        end else if (tx_ready) begin
            m_frames = m_frames + 32'd1;
            m_owner  = -1;
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock with the inputs already driven, then compare against the model.
    task automatic tick();
        logic [3:0] e_pop;
        logic [3:0] e_gr;
        logic       e_tv;
        model_step();
        @(posedge clk);
        @(negedge clk);
        e_pop = m_issue ? (4'b0001 << m_owner) : 4'b0000;
        e_gr  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e_tv  = m_issue && tx_ready;
        if (m_issue) $display("txn: port %0d ptr %02h frames %0d", m_owner, m_ptr, m_frames);
        chk("model_outputs", 64'({req_pop, tx_valid, tx_ptr, grant, err_timeout}),
                             64'({e_pop, e_tv, m_ptr, e_gr, m_err}));
        chk("model_frame_cnt", 64'(frame_cnt), 64'(m_frames));
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [3:0] en;
        logic       rdy;
        logic [3:0] e_pop;
        logic       e_tv;
        logic [3:0] e_gr;
        logic [7:0] e_ptr;
        int         e_frames;
    } vec_t;

    vec_t vecs[21];
    int   order[6];
    int   mac_hi;
    int   mac_lo;

    initial begin
        vecs[0]  = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100, 8'h0a, 0};
        vecs[1]  = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0100, 8'h0a, 0};
        vecs[2]  = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0100, 8'h0a, 0};
        vecs[3]  = '{4'b0011, 4'b1110, 1'b0, 4'b0000, 1'b0, 4'b0100, 8'h0a, 0};
        vecs[4]  = '{4'b0011, 4'b1110, 1'b1, 4'b0000, 1'b0, 4'b0000, 8'h0a, 1};
        vecs[5]  = '{4'b0011, 4'b1110, 1'b1, 4'b0010, 1'b1, 4'b0010, 8'h21, 1};
        vecs[6]  = '{4'b0011, 4'b1110, 1'b1, 4'b0000, 1'b0, 4'b0010, 8'h21, 1};
        vecs[7]  = '{4'b0011, 4'b1110, 1'b0, 4'b0000, 1'b0, 4'b0010, 8'h21, 1};
        vecs[8]  = '{4'b1001, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, 8'h21, 2};
        vecs[9]  = '{4'b1000, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000, 8'h30, 2};
        vecs[10] = '{4'b1001, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b1000, 8'h30, 2};
        vecs[11] = '{4'b1001, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b1000, 8'h30, 2};
        vecs[12] = '{4'b1001, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, 8'h30, 3};
        vecs[13] = '{4'b1001, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'h40, 3};
        vecs[14] = '{4'b1001, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0001, 8'h40, 3};
        vecs[15] = '{4'b1001, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0001, 8'h40, 3};
        vecs[16] = '{4'b1001, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, 8'h40, 4};
        vecs[17] = '{4'b1001, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000, 8'h30, 4};
        vecs[18] = '{4'b1001, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b1000, 8'h30, 4};
        vecs[19] = '{4'b1001, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b1000, 8'h30, 4};
        vecs[20] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, 8'h30, 5};
        order = '{0, 1, 3, 0, 1, 3};

        rst = 1'b1; req_valid = 4'b0000; port_en = 4'b1111; tx_ready = 1'b0;
        req_ptr = {8'h30, 8'h0a, 8'h21, 8'h40};
        tick();
        tick();
        chk("reset_outputs", 64'({req_pop, tx_valid, tx_ptr, grant, err_timeout, frame_cnt}), 64'd0);
        rst = 1'b0;

        // Directed vectors: single request, mask, wrap-around.
        for (int v = 0; v < 21; v++) begin
            req_valid = vecs[v].valid; port_en = vecs[v].en; tx_ready = vecs[v].rdy;
            tick();
            chk($sformatf("vec%0d_pop", v),    64'(req_pop),   64'(vecs[v].e_pop));
            chk($sformatf("vec%0d_valid", v),  64'(tx_valid),  64'(vecs[v].e_tv));
            chk($sformatf("vec%0d_grant", v),  64'(grant),     64'(vecs[v].e_gr));
            chk($sformatf("vec%0d_ptr", v),    64'(tx_ptr),    64'(vecs[v].e_ptr));
            chk($sformatf("vec%0d_frames", v), 64'(frame_cnt), 64'(vecs[v].e_frames));
        end

        // Long frame on port 2: ready drops at k+2, rises at k+80.
        req_valid = 4'b0100; tx_ready = 1'b1;
        tick();
        chk("long_pop", 64'(req_pop), 64'h4);
        chk("long_ptr", 64'(tx_ptr), 64'h0a);
        req_valid = 4'b0000;
        tick();
        tx_ready = 1'b0;
        repeat (78) tick();
        chk("long_frames_before", 64'(frame_cnt), 64'd5);
        chk("long_grant_held", 64'(grant), 64'h4);
        tx_ready = 1'b1;
        tick();
        chk("long_frames_after", 64'(frame_cnt), 64'd6);

        // Busy timeout: ready never drops after ISSUE.
        req_valid = 4'b0100;
        tick();
        chk("to_pop", 64'(req_pop), 64'h4);
        req_valid = 4'b0000;
        tick();
        repeat (63) tick();
        chk("to_err_early", 64'(err_timeout), 64'd0);
        tick();
        chk("to_err_set", 64'(err_timeout), 64'd1);
        chk("to_grant_clear", 64'(grant), 64'd0);
        chk("to_frames", 64'(frame_cnt), 64'd6);
        req_valid = 4'b0010;
        tick();
        chk("to_next_pop", 64'(req_pop), 64'h2);

        // Reset while the MAC is finishing the frame.
        req_valid = 4'b0000;
        tick();
        tx_ready = 1'b0;
        tick();
        chk("rst_grant_before", 64'(grant), 64'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_outputs", 64'({req_pop, tx_valid, tx_ptr, grant, err_timeout}), 64'd0);
        chk("rst_mid_frames", 64'(frame_cnt), 64'd0);

        // Contention rotation among ports 0,1,3.
        req_valid = 4'b1011; port_en = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tx_ready = 1'b1;
            tick();
            chk($sformatf("rot%0d_pop", i), 64'(req_pop), 64'(4'b0001 << order[i]));
            tick();
            tx_ready = 1'b0;
            repeat (3) tick();
            tx_ready = 1'b1;
            tick();
        end
        chk("rot_frames", 64'(frame_cnt), 64'd6);

        // Randomized traffic with a reactive MAC.
        mac_hi = 0; mac_lo = 0;
        for (int c = 0; c < 3000; c++) begin
            if (mac_hi > 0) begin
                tx_ready = 1'b1; mac_hi--;
            end else if (mac_lo > 0) begin
                tx_ready = 1'b0; mac_lo--;
            end else begin
                tx_ready = ($urandom_range(0, 7) != 0);
            end
            req_valid = 4'($urandom());
            port_en   = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'b1111;
            req_ptr   = $urandom();
            tick();
            if (tx_valid) begin
                mac_hi = 1 + (($urandom_range(0, 15) == 0) ? 70 : int'($urandom_range(0, 2)));
                mac_lo = $urandom_range(1, 8);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/voq_tx_scheduler.md
Name: voq_tx_scheduler

Overview:
Per-output-port scheduler between the NUM_PORTS virtual output queues (one per ingress port) and tx_mac_control.
- Round-robin arbitration among non-empty, enabled VOQs.
- Issues the winner's head frame pointer to tx_mac_control via its voq_valid/voq_ptr/voq_ready handshake.
- Pops the winner's VOQ and holds off further grants until the MAC finishes the frame and its IFG.

Parameters:
NUM_PORTS, 4, number of ingress VOQs feeding this output port
VOQ_DEPTH, 256, frame-memory depth; PTR_W = $clog2(VOQ_DEPTH)
BUSY_TIMEOUT, 64, max cycles after issue for tx_ready_i to deassert

Ports:
switch_clk  in  1  switch clock, 500 MHz
switch_rst  in  1  synchronous, active-high reset
req_valid_i  in  NUM_PORTS  VOQ[i] non-empty
req_ptr_i  in  NUM_PORTS*PTR_W  head pointer of VOQ[i], slice i at [i*PTR_W +: PTR_W]
req_pop_o  out  NUM_PORTS  one-cycle pop pulse to winning VOQ
port_en_i  in  NUM_PORTS  per-VOQ enable mask
tx_valid_o  out  1  to tx_mac_control voq_valid_i
tx_ptr_o  out  PTR_W  to tx_mac_control voq_ptr_i
tx_ready_i  in  1  from tx_mac_control voq_ready_o
grant_o  out  NUM_PORTS  one-hot owner of in-flight frame
frame_cnt_o  out  32  frames completed
err_timeout_o  out  1  sticky busy-timeout flag

Behaviour:
- Reset:
  - all outputs 0
  - state IDLE
  - rr_last = NUM_PORTS-1, so port 0 has first priority
  - timeout counter 0
- Reset mid-frame abandons the frame; no pop is reissued.
- eligible = req_valid_i & port_en_i.
- IDLE:
  - If tx_ready_i=1 and eligible≠0 in cycle k, select the first eligible port scanning rr_last+1, rr_last+2, … modulo NUM_PORTS.
  - Latch its pointer, set rr_last = winner, go ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (cycle k+1, exactly one cycle):
  - tx_valid_o=1, tx_ptr_o = latched pointer, req_pop_o[winner]=1.
  - grant_o = onehot(winner); grant_o is held through WAIT_DONE.
  - Next state WAIT_BUSY.
  - tx_ptr_o holds its value until the next ISSUE.
- WAIT_BUSY:
  - Counter increments each cycle.
  - tx_ready_i=0 → WAIT_DONE, counter cleared.
  - Counter reaches BUSY_TIMEOUT with tx_ready_i still 1 → set err_timeout_o, clear grant_o, go IDLE. frame_cnt_o is not incremented.
- WAIT_DONE:
  - tx_ready_i=1 → frame_cnt_o+1 (wraps modulo 2^32), grant_o=0, go IDLE.
  - Earliest next ISSUE is 2 cycles after tx_ready_i rises.
- tx_valid_o is never asserted while tx_ready_i=0 or outside ISSUE.
- Requests, port_en_i and req_ptr_i changes after the IDLE decision cycle do not affect the in-flight frame.
- A VOQ deasserting req_valid_i while not granted is legal; it is simply skipped.
- A single eligible port may win back-to-back. Round-robin only matters under contention.
- err_timeout_o clears only on reset.

Decomposition:
- Package voq_sched_pkg:
  - state enum {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE}
  - ptr width function/localparam
- One sub-module rr_arbiter: combinational masked round-robin pick.
  - Parameter NUM_PORTS.
  - Inputs: req vector, rr_last.
  - Outputs: one-hot grant, index, any.
- Scheduler FSM, latches and counters live in the top module.

Test Plan:
- Single request:
  - Stimulus: port 2 valid, ptr 8'd10, tx_ready_i=1 at cycle k.
  - Response: tx_valid_o=1 and req_pop_o=4'b0100 at k+1, tx_ptr_o=10, grant_o=4'b0100.
  - Then MAC model drops ready at k+2 and raises it at k+80 → frame_cnt_o=1 at k+81.
- Contention rotation:
  - Stimulus: ports 0,1,3 all valid continuously, MAC model completing each frame.
  - Response: grant order 0,1,3,0,1,3; frame_cnt_o=6 after six frames.
- Mask:
  - Stimulus: port_en_i=4'b1110, ports 0 and 1 valid.
  - Response: only port 1 is granted; port 0 is never popped.
- Wrap-around:
  - Stimulus: rr_last=3, ports 0 and 3 valid.
  - Response: port 0 wins; the next grant is port 3.
- Busy timeout:
  - Stimulus: tx_ready_i held at 1 after ISSUE.
  - Response: err_timeout_o=1 exactly BUSY_TIMEOUT=64 cycles into WAIT_BUSY; state IDLE; frame_cnt_o unchanged; next grant proceeds normally.
- Reset mid-frame:
  - Stimulus: switch_rst=1 for 1 cycle during WAIT_DONE.
  - Response: next cycle all outputs 0, frame_cnt_o=0, err_timeout_o=0; port 0 has first priority afterwards.
